// File: rtl/seg7_msg_sequencer_if.sv
// seg7_msg_sequencer_if
// Control and status bundle between a top-level controller and the
// "JOSE SAUL" 7-segment message sequencer. The controller (master) drives
// start/stop/loop_en. The sequencer (slave) returns the letter code and status.
interface seg7_msg_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] digit;
  logic [3:0] pos;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output stop,
    output loop_en,
    input  digit,
    input  pos,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    input  loop_en,
    output digit,
    output pos,
    output busy,
    output done
  );
endinterface

// File: rtl/seg7_msg_sequencer.sv
// seg7_msg_sequencer
// Steps the 4-bit letter code fed to the 7-segment letter decoder through the
// message J O S E _ S A U L _ . Each position is held for TICK_DIV clocks.
// Playback runs either once or in a loop. It has start/stop control and
// busy/done status outputs.
//
// Optional build macro SEQ_BLINK_EN:
//   When defined, the letter is blanked for the second half of each hold
//   period (prescaler >= TICK_DIV/2). This separates repeated letters on the
//   display. Position, busy and done timing are unaffected.
module seg7_msg_sequencer #(
  parameter int TICK_DIV = 1000000,
  parameter int DIV_W    = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  seg7_msg_sequencer_if.slave  bus
);

  localparam logic [3:0]       LAST_POS  = 4'd9;
  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
`ifdef SEQ_BLINK_EN
  localparam logic [DIV_W-1:0] BLINK_AT  = DIV_W'(TICK_DIV / 2);
`endif

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] prescaler_q, prescaler_d;
  logic [3:0]       pos_q, pos_d;
  logic [3:0]       digit_q, digit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             terminalTick;
  logic             lastPos;
  logic             blankNow;

  // Message ROM: position -> decoder code (0 = blank, 1..8 = J O S E S A U L).
  function automatic logic [3:0] romCode(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = 4'd4;
      4'd4:    code = 4'd0;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = 4'd7;
      4'd8:    code = 4'd8;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  assign terminalTick = (prescaler_q == TICK_LAST);
  assign lastPos      = (pos_q == LAST_POS);

  // Blank the letter in the upper half of the hold period when blink is built in.
  always_comb begin
`ifdef SEQ_BLINK_EN
    blankNow = (prescaler_d >= BLINK_AT);
`else
    blankNow = 1'b0;
`endif
  end

  // Next-state logic. stop outranks the terminal tick. start is ignored once showing.
  always_comb begin
    state_d     = state_q;
    prescaler_d = prescaler_q;
    pos_d       = pos_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        prescaler_d = '0;
        pos_d       = 4'd0;
        if (bus.start && !bus.stop) begin
          state_d = SHOW;
        end
      end

      SHOW: begin
        if (bus.stop) begin
          state_d     = IDLE;
          prescaler_d = '0;
          pos_d       = 4'd0;
        end else if (terminalTick) begin
          prescaler_d = '0;
          if (lastPos) begin
            pos_d = 4'd0;
            if (!bus.loop_en) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end else begin
          prescaler_d = prescaler_q + DIV_W'(1);
        end
      end

      default: begin
        state_d     = IDLE;
        prescaler_d = '0;
        pos_d       = 4'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so they line up with pos in the same cycle.
  always_comb begin
    busy_d  = (state_d == SHOW);
    digit_d = 4'd0;
    if (state_d == SHOW && !blankNow) begin
      digit_d = romCode(pos_d);
    end
  end

  // State and output registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      pos_q       <= 4'd0;
      digit_q     <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prescaler_q <= prescaler_d;
      pos_q       <= pos_d;
      digit_q     <= digit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.digit = digit_q;
  assign bus.pos   = pos_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_seg7_msg_sequencer.sv
// tb_seg7_msg_sequencer
// Directed bench for seg7_msg_sequencer with TICK_DIV = 4. Each stimulus step
// queues the outputs expected after the next clock edge. An independent
// monitor pops and compares once per cycle on the falling edge.
module tb_seg7_msg_sequencer;

  localparam int TD = 4;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] pos;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t expQ[$];

  seg7_msg_sequencer_if bus();

  seg7_msg_sequencer #(
    .TICK_DIV (TD),
    .DIV_W    (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Letter codes of the message, by position.
  function automatic logic [3:0] codeOf(input int p);
    case (p)
      0: return 4'd1;
      1: return 4'd2;
      2: return 4'd3;
      3: return 4'd4;
      5: return 4'd5;
      6: return 4'd6;
      7: return 4'd7;
      8: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // Expected outputs k cycles after playback began (k = 0 is the first letter cycle).
  function automatic exp_t expShow(input int k, input string nm);
    exp_t e;
    int   p;
    int   ph;
    p  = (k / TD) % 10;
    ph = k % TD;
    e.digit = codeOf(p);
`ifdef SEQ_BLINK_EN
    if (ph >= TD / 2) e.digit = 4'd0;
`else
    if (ph < 0) e.digit = 4'd0;
`endif
    e.pos  = 4'(p);
    e.busy = 1'b1;
    e.done = 1'b0;
    e.name = nm;
    return e;
  endfunction

  // Expected outputs while idle, optionally in the completion cycle.
  function automatic exp_t expIdle(input logic dn, input string nm);
    exp_t e;
    e.digit = 4'd0;
    e.pos   = 4'd0;
    e.busy  = 1'b0;
    e.done  = dn;
    e.name  = nm;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show after the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic sp,
                               input logic lp, input exp_t e);
    rst         = r;
    bus.start   = s;
    bus.stop    = sp;
    bus.loop_en = lp;
    @(posedge clk);
    #1;
    expQ.push_back(e);
  endtask

  // Compare one observed output set against its queued expectation.
  task automatic checkOutput(input exp_t e);
    total++;
    if (bus.digit !== e.digit || bus.pos !== e.pos ||
        bus.busy !== e.busy || bus.done !== e.done) begin
      bad++;
      $display("[TB] FAIL %s: got digit=%0d pos=%0d busy=%0b done=%0b, expected digit=%0d pos=%0d busy=%0b done=%0b",
               e.name, bus.digit, bus.pos, bus.busy, bus.done,
               e.digit, e.pos, e.busy, e.done);
    end
  endtask

  // Monitor: consume one expectation per cycle, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  // Directed scenarios.
  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.loop_en = 1'b0;

    // Reset held two cycles, then idle with start low.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "reset"));
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "idle_no_start"));

    // Single-shot pass: 40 letter cycles, done in the 41st, then blank.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, expShow(0, "single_first"));
    for (int k = 1; k < 40; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expShow(k, "single_pass"));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b1, "single_done"));
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "single_after"));

    // Looping playback for 100 cycles: wraps to J at pos 0, never done.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, expShow(0, "loop_first"));
    for (int k = 1; k < 100; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, expShow(k, "loop_pass"));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, expIdle(1'b0, "loop_stop"));

    // Stop while showing position 6: straight to idle, no done.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, expShow(0, "stop_first"));
    for (int k = 1; k < 26; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expShow(k, "stop_pass"));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, expIdle(1'b0, "stop_at_pos6"));
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "stop_after"));

    // start and stop together from idle: stop wins.
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, expIdle(1'b0, "start_stop_idle"));

    // Second start at pos 3 is ignored; loop_en dropped mid-pass ends single-shot.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, expShow(0, "restart_first"));
    for (int k = 1; k < 40; k++)
      applyStimulus(1'b0, (k == 13), 1'b0, (k < 20), expShow(k, "restart_pass"));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b1, "restart_done"));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "restart_after"));

    // Reset while showing position 7.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, expShow(0, "rst_first"));
    for (int k = 1; k < 30; k++)
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expShow(k, "rst_pass"));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "rst_mid_pos7"));
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, expIdle(1'b0, "rst_after"));

    // Let the monitor drain the last expectation.
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_msg_sequencer.md
Name: seg7_msg_sequencer

Overview:
- Drives the 4-bit `digit` code consumed by the 7-segment letter decoder so the display spells "JOSE SAUL" one letter at a time.
- Sequence order: J O S E blank S A U L blank.
- A prescaled timebase sets how long each letter is held.
- Single-shot or looping playback, with start/stop control and status outputs for the top level.

Parameters:
- TICK_DIV, 1000000, clock cycles each letter is held; legal range 1..2^DIV_W-1.
- DIV_W, 24, width of the prescaler counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  level sampled each cycle; begins playback from IDLE.
- stop  input  1  aborts playback and returns to IDLE.
- loop_en  input  1  1 = wrap from last position to first; 0 = single-shot.
- digit  output  4  code to the decoder, registered; 0 = blank, 1..8 = J,O,S,E,S,A,U,L.
- pos  output  4  current message index, 0..9.
- busy  output  1  high while in SHOW.
- done  output  1  one-cycle pulse when a single-shot pass completes.

Behaviour:
- Message ROM, index -> code: 0->1, 1->2, 2->3, 3->4, 4->0, 5->5, 6->6, 7->7, 8->8, 9->0. MSG_LEN is fixed at 10.
- Synchronous reset, active high:
  - State = IDLE.
  - Prescaler = 0, pos = 0, digit = 0, busy = 0, done = 0.
  - Reset overrides every other input, including mid-playback.
- Reset is synchronous and active-high on port rst; single clock domain on clk.
- States: IDLE, SHOW.
- IDLE:
  - digit = 0, busy = 0, pos = 0.
  - start = 1 and stop = 0 -> SHOW at the next edge, with prescaler = 0, pos = 0, digit = 1 (J), busy = 1.
  - Latency: one clock from start sampled to the first letter on digit.
  - start and stop both high -> stay in IDLE; stop wins.
- SHOW:
  - Prescaler increments every clock.
  - When prescaler == TICK_DIV-1: prescaler -> 0 and pos advances.
  - digit = ROM[pos], registered so that it always matches pos in the same cycle.
- End of message, at the terminal tick with pos == 9:
  - loop_en = 1 -> pos = 0, digit = 1, remain in SHOW, no done.
  - loop_en = 0 -> IDLE, pos = 0, digit = 0, busy = 0, done = 1 for exactly one cycle.
  - loop_en is sampled only at that terminal tick, so changing it mid-pass has no effect until then.
- stop = 1 in SHOW:
  - -> IDLE at the next edge; digit = 0, busy = 0, pos = 0.
  - No done pulse.
  - stop takes priority over a coincident terminal tick.
- start in SHOW is ignored: no restart, no counter disturbance.
- done is 0 in every cycle except the single completion cycle.
- TICK_DIV = 1: pos advances every clock; a full pass takes 10 cycles.
- Prescaler terminal compare uses the full DIV_W width; no wrap before TICK_DIV-1.

Optional Feature:
- Macro: SEQ_BLINK_EN.
- Defined:
  - In SHOW, digit is forced to 0 while prescaler >= TICK_DIV/2 (integer division).
  - This inserts a blank gap so repeated letters (S, then S after the blank) are visually separated.
  - pos, busy and done timing are unchanged.
  - For TICK_DIV = 1 the condition prescaler >= 0 always holds, so digit is blank throughout SHOW.
- Undefined: digit holds ROM[pos] for the full TICK_DIV period. Ports are identical in both builds.

Test Plan:
- All scenarios use TICK_DIV = 4 and the macro undefined unless stated.
- Reset, then idle: rst high for 2 cycles -> digit = 0, pos = 0, busy = 0, done = 0; start held low for 10 cycles -> outputs unchanged.
- Single-shot pass:
  - One-cycle start pulse with loop_en = 0 -> digit shows 1, 2, 3, 4, 0, 5, 6, 7, 8, 0, each for 4 cycles.
  - busy high for 40 cycles; done high exactly 1 cycle at cycle 41 after start; then digit = 0.
- Loop: loop_en = 1, start -> after 40 cycles digit returns to 1 and pos = 0, busy stays 1, done never asserts over 100 cycles.
- Stop mid-pass and priority:
  - stop asserted at pos = 6 -> next cycle busy = 0, digit = 0, pos = 0, no done.
  - start with stop in the same cycle from IDLE -> remains IDLE.
- Restart ignored and reset mid-operation:
  - start pulse at pos = 3 -> sequence timing unchanged.
  - rst at pos = 7 -> all outputs return to reset values the next cycle.
- SEQ_BLINK_EN defined: during each 4-cycle letter, digit = code for 2 cycles then 0 for 2 cycles; done still at cycle 41.
